// File: rtl/s32x_pkg.sv
// Shared 32X types and constants.
// Holds the SDRAM responder FSM encoding and the data returned on a timed-out read.
package s32x_pkg;

    typedef enum logic [1:0] {
        SR_IDLE,
        SR_BUSY,
        SR_DONE
    } sdr_resp_state_t;

    localparam logic [15:0] SDR_TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/s32x_sdr_responder.sv
// SH-2 SDRAM request bus responder: holds SDR_WAIT while forwarding one
// access at a time to a req/ack memory-controller channel.
module s32x_sdr_responder
    import s32x_pkg::*;
#(
    parameter int ADDR_W   = 17,
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] SDR_A,
    input  logic [15:0]       SDR_DO,
    input  logic              SDR_CS,
    input  logic [1:0]        SDR_WE,
    input  logic              SDR_RD,
    output logic [15:0]       SDR_DI,
    output logic              SDR_WAIT,
    output logic [ADDR_W-1:0] MEM_A,
    output logic [15:0]       MEM_DO,
    output logic [1:0]        MEM_WE,
    output logic              MEM_REQ,
    input  logic [15:0]       MEM_DI,
    input  logic              MEM_ACK,
    output logic              ERR
);

    localparam int WW = $clog2(MIN_WAIT + 1);
    localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    sdr_resp_state_t   r_state;
    sdr_resp_state_t   w_state_nxt;

    logic [WW-1:0]     r_wait_cnt;
    logic [TW-1:0]     r_to_cnt;
    logic              r_acked;
    logic              r_req;
    logic              r_err;
    logic [15:0]       r_di;
    logic [ADDR_W-1:0] r_mem_a;
    logic [15:0]       r_mem_do;
    logic [1:0]        r_mem_we;

    logic              w_req;
    logic              w_ack;
    logic              w_to_hit;
    logic              w_wait_last;
    logic              w_fin;
    logic              w_start;
    logic              w_busy;
    logic              w_is_rd;

    assign w_req       = SDR_CS & (SDR_RD | (|SDR_WE));
    // Acks outside an outstanding request (e.g. after a timeout) are dropped.
    assign w_ack       = MEM_ACK & r_req;
    assign w_to_hit    = (TIMEOUT != 0) && r_req && !MEM_ACK
                         && (r_to_cnt == TW'(TIMEOUT - 1));
    assign w_wait_last = (r_wait_cnt <= WW'(1));
    assign w_is_rd     = ~|r_mem_we;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            SR_IDLE: if (w_req) w_state_nxt = SR_BUSY;
            SR_BUSY: if (w_fin) w_state_nxt = w_req ? SR_DONE : SR_IDLE;
            SR_DONE: if (!w_req) w_state_nxt = SR_IDLE;
            default: w_state_nxt = SR_IDLE;
        endcase
    end

    always_comb begin
        w_start = 1'b0;
        w_busy  = 1'b0;
        w_fin   = 1'b0;
        unique case (r_state)
            SR_IDLE: w_start = w_req;
            SR_BUSY: begin
                w_busy = 1'b1;
                w_fin  = (r_acked | w_ack | w_to_hit) & w_wait_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= SR_IDLE;
            r_wait_cnt <= '0;
            r_to_cnt   <= '0;
            r_acked    <= 1'b0;
            r_req      <= 1'b0;
            r_err      <= 1'b0;
            r_di       <= '0;
            r_mem_a    <= '0;
            r_mem_do   <= '0;
            r_mem_we   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_mem_a    <= SDR_A;
                r_mem_do   <= SDR_DO;
                r_mem_we   <= SDR_WE;
                r_req      <= 1'b1;
                r_wait_cnt <= WW'(MIN_WAIT);
                r_to_cnt   <= '0;
                r_acked    <= 1'b0;
            end else if (w_busy) begin
                if (r_wait_cnt != '0)
                    r_wait_cnt <= r_wait_cnt - 1'b1;
                if (r_req && (r_to_cnt != '1))
                    r_to_cnt <= r_to_cnt + 1'b1;
                if (w_ack) begin
                    r_req   <= 1'b0;
                    r_acked <= 1'b1;
                    if (w_is_rd)
                        r_di <= MEM_DI;
                end else if (w_to_hit) begin
                    r_req   <= 1'b0;
                    r_acked <= 1'b1;
                    r_err   <= 1'b1;
                    if (w_is_rd)
                        r_di <= SDR_TIMEOUT_DATA;
                end
            end
        end
    end

    assign SDR_WAIT = (r_state == SR_BUSY);
    assign SDR_DI   = r_di;
    assign MEM_A    = r_mem_a;
    assign MEM_DO   = r_mem_do;
    assign MEM_WE   = r_mem_we;
    assign MEM_REQ  = r_req;
    assign ERR      = r_err;

endmodule

// File: tb/tb_s32x_sdr_responder.sv
// Directed bench for the SDRAM responder: read, byte write, held request,
// immediate ack, timeout and reset mid-access.
module tb_s32x_sdr_responder;

    logic        CLK;
    logic        RST;
    logic [16:0] SDR_A;
    logic [15:0] SDR_DO;
    logic        SDR_CS;
    logic [1:0]  SDR_WE;
    logic        SDR_RD;
    logic [15:0] SDR_DI;
    logic        SDR_WAIT;
    logic [16:0] MEM_A;
    logic [15:0] MEM_DO;
    logic [1:0]  MEM_WE;
    logic        MEM_REQ;
    logic [15:0] MEM_DI;
    logic        MEM_ACK;
    logic        ERR;

    int n_checks = 0;
    int n_errors = 0;
    int n_req;
    int n_wait;

    s32x_sdr_responder #(
        .ADDR_W  (17),
        .MIN_WAIT(2),
        .TIMEOUT (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SDR_A   (SDR_A),
        .SDR_DO  (SDR_DO),
        .SDR_CS  (SDR_CS),
        .SDR_WE  (SDR_WE),
        .SDR_RD  (SDR_RD),
        .SDR_DI  (SDR_DI),
        .SDR_WAIT(SDR_WAIT),
        .MEM_A   (MEM_A),
        .MEM_DO  (MEM_DO),
        .MEM_WE  (MEM_WE),
        .MEM_REQ (MEM_REQ),
        .MEM_DI  (MEM_DI),
        .MEM_ACK (MEM_ACK),
        .ERR     (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_di"},   32'(SDR_DI),   32'h0);
        chk({tag, "_wait"}, 32'(SDR_WAIT), 32'h0);
        chk({tag, "_ma"},   32'(MEM_A),    32'h0);
        chk({tag, "_mdo"},  32'(MEM_DO),   32'h0);
        chk({tag, "_mwe"},  32'(MEM_WE),   32'h0);
        chk({tag, "_mreq"}, 32'(MEM_REQ),  32'h0);
        chk({tag, "_err"},  32'(ERR),      32'h0);
    endtask

    initial begin
        RST = 1'b1;
        SDR_A = '0; SDR_DO = '0; SDR_CS = 1'b0; SDR_WE = 2'b00; SDR_RD = 1'b0;
        MEM_DI = '0; MEM_ACK = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        RST = 1'b0;
        tick();

        // Read, ack sampled 3 cycles after MEM_REQ rises
        SDR_A = 17'h00123; SDR_CS = 1'b1; SDR_RD = 1'b1;
        chk("rd_wait_pre", 32'(SDR_WAIT), 32'h0);
        tick();
        chk("rd_wait_rise", 32'(SDR_WAIT), 32'h1);
        chk("rd_mreq",      32'(MEM_REQ),  32'h1);
        chk("rd_ma",        32'(MEM_A),    32'h00123);
        chk("rd_mwe",       32'(MEM_WE),   32'h0);
        tick();
        tick();
        chk("rd_wait_hold", 32'(SDR_WAIT), 32'h1);
        chk("rd_mreq_hold", 32'(MEM_REQ),  32'h1);
        MEM_ACK = 1'b1; MEM_DI = 16'hBEEF;
        tick();
        MEM_ACK = 1'b0; MEM_DI = 16'h0000;
        chk("rd_wait_fall", 32'(SDR_WAIT), 32'h0);
        chk("rd_mreq_fall", 32'(MEM_REQ),  32'h0);
        chk("rd_di",        32'(SDR_DI),   32'hBEEF);
        SDR_CS = 1'b0; SDR_RD = 1'b0;
        tick();

        // Byte write with immediate ack; request dropped while busy
        SDR_A = 17'h1ABCD; SDR_CS = 1'b1; SDR_WE = 2'b10; SDR_DO = 16'hA55A;
        tick();
        chk("wr_wait_rise", 32'(SDR_WAIT), 32'h1);
        chk("wr_mwe",       32'(MEM_WE),   32'h2);
        chk("wr_mdo",       32'(MEM_DO),   32'hA55A);
        chk("wr_ma",        32'(MEM_A),    32'h1ABCD);
        MEM_ACK = 1'b1; MEM_DI = 16'h9999;
        tick();
        MEM_ACK = 1'b0; MEM_DI = 16'h0000;
        chk("wr_wait_min", 32'(SDR_WAIT), 32'h1);
        chk("wr_mreq_off", 32'(MEM_REQ),  32'h0);
        SDR_CS = 1'b0; SDR_WE = 2'b00;
        tick();
        chk("wr_wait_fall", 32'(SDR_WAIT), 32'h0);
        chk("wr_di_keep",   32'(SDR_DI),   32'hBEEF);

        // Dropped request went straight to IDLE, so a new one starts at once
        SDR_A = 17'h00055; SDR_CS = 1'b1; SDR_RD = 1'b1;
        tick();
        chk("skip_done_wait", 32'(SDR_WAIT), 32'h1);
        chk("skip_done_ma",   32'(MEM_A),    32'h00055);
        MEM_ACK = 1'b1; MEM_DI = 16'h1234;
        tick();
        MEM_ACK = 1'b0;
        tick();
        chk("held_wait_fall", 32'(SDR_WAIT), 32'h0);
        chk("held_di",        32'(SDR_DI),   32'h1234);

        // Request held after completion must not retrigger
        n_req = 0;
        n_wait = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (MEM_REQ) n_req++;
            if (SDR_WAIT) n_wait++;
        end
        chk("held_no_req",  32'(n_req),  32'h0);
        chk("held_no_wait", 32'(n_wait), 32'h0);
        SDR_CS = 1'b0; SDR_RD = 1'b0;
        tick();
        SDR_A = 17'h00056; SDR_CS = 1'b1; SDR_RD = 1'b1;
        tick();
        chk("rearm_mreq", 32'(MEM_REQ),  32'h1);
        chk("rearm_ma",   32'(MEM_A),    32'h00056);
        MEM_ACK = 1'b1; MEM_DI = 16'h7777;
        tick();
        MEM_ACK = 1'b0;
        tick();
        chk("rearm_di", 32'(SDR_DI), 32'h7777);
        SDR_CS = 1'b0; SDR_RD = 1'b0;
        tick();

        // Timeout on a read that is never acked
        SDR_A = 17'h1FFFF; SDR_CS = 1'b1; SDR_RD = 1'b1;
        tick();
        n_req = 0;
        for (int i = 0; i < 7; i++) begin
            if (MEM_REQ) n_req++;
            tick();
        end
        if (MEM_REQ) n_req++;
        chk("to_req_cycles", 32'(n_req), 32'h8);
        chk("to_err_pre",    32'(ERR),   32'h0);
        tick();
        chk("to_mreq", 32'(MEM_REQ),  32'h0);
        chk("to_err",  32'(ERR),      32'h1);
        chk("to_di",   32'(SDR_DI),   32'hFFFF);
        chk("to_wait", 32'(SDR_WAIT), 32'h0);
        MEM_ACK = 1'b1; MEM_DI = 16'h1111;
        tick();
        MEM_ACK = 1'b0;
        chk("late_di",   32'(SDR_DI),   32'hFFFF);
        chk("late_err",  32'(ERR),      32'h1);
        chk("late_mreq", 32'(MEM_REQ),  32'h0);
        chk("late_wait", 32'(SDR_WAIT), 32'h0);
        SDR_CS = 1'b0; SDR_RD = 1'b0;
        tick();

        // Reset while busy aborts the access immediately
        SDR_A = 17'h00042; SDR_CS = 1'b1; SDR_WE = 2'b01; SDR_DO = 16'h5A5A;
        tick();
        chk("rb_mreq", 32'(MEM_REQ), 32'h1);
        RST = 1'b1;
        #1;
        chk_reset_vals("rb");
        SDR_CS = 1'b0; SDR_WE = 2'b00;
        tick();
        RST = 1'b0;
        tick();
        SDR_A = 17'h00077; SDR_CS = 1'b1; SDR_RD = 1'b1;
        tick();
        chk("post_wait", 32'(SDR_WAIT), 32'h1);
        chk("post_ma",   32'(MEM_A),    32'h00077);
        MEM_ACK = 1'b1; MEM_DI = 16'hCAFE;
        tick();
        MEM_ACK = 1'b0;
        tick();
        chk("post_di",   32'(SDR_DI),   32'hCAFE);
        chk("post_fall", 32'(SDR_WAIT), 32'h0);
        chk("post_err",  32'(ERR),      32'h0);
        SDR_CS = 1'b0; SDR_RD = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
